// File: rtl/plic_gen2_if.sv
// rtl/plic_gen2_if.sv - AXI4-Lite register port bundle used by plic_gen2
interface axi4lite_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic [AWIDTH-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DWIDTH-1:0] wdata;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [AWIDTH-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DWIDTH-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport target_port (
      input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport initiator_port (
      output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/plic_gen2.sv
// rtl/plic_gen2.sv - platform-level interrupt controller with level/edge gateways,
// registered per-context arbiters and owner-checked claim/complete over AXI4-Lite
module plic_gen2 #(
   parameter int AWIDTH      = 32,
   parameter int DWIDTH      = 32,
   parameter int NUM_SOURCES = 32,
   parameter int NUM_TARGETS = 2,
   parameter int PRIO_W      = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_SOURCES-1:0] source,
   output logic [NUM_TARGETS-1:0] target,
   axi4lite_if.target_port        axi_if
);
   localparam int NW = (NUM_SOURCES + 31) / 32;
   localparam int IW = $clog2(NUM_SOURCES);
   localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam logic [NUM_SOURCES-1:0] SRC_MASK = {{(NUM_SOURCES-1){1'b1}}, 1'b0};

   typedef struct packed {
      logic       is_prio;
      logic       is_trig;
      logic       is_en;
      logic       is_thr;
      logic       is_claim;
      logic [9:0] idx;
      logic [4:0] word;
      logic [5:0] ctx;
   } dec_t;

   // Full decode of every address bit so aliases above the map read as unmapped
   function automatic dec_t decode(input logic [AWIDTH-1:0] a);
      dec_t d;
      d      = '0;
      d.idx  = a[11:2];
      d.word = a[6:2];
      d.ctx  = a[12:7];
      if (a[1:0] == 2'b00) begin
         d.is_prio = (a[AWIDTH-1:12] == '0) && (32'(a[11:2]) < NUM_SOURCES);
         d.is_trig = (a[AWIDTH-1:7] == (AWIDTH-7)'(32'h21)) && (32'(a[6:2]) < NW);
         d.is_en   = (a[AWIDTH-1:13] == (AWIDTH-13)'(32'h1)) && (32'(a[12:7]) < NUM_TARGETS)
                     && (32'(a[6:2]) < NW);
         if ((a[AWIDTH-1:18] == (AWIDTH-18)'(32'h8)) && (a[11:3] == '0)
             && (32'(a[17:12]) < NUM_TARGETS)) begin
            d.ctx      = a[17:12];
            d.is_thr   = !a[2];
            d.is_claim = a[2];
         end
      end
      return d;
   endfunction

   logic [PRIO_W-1:0]      prio    [NUM_SOURCES];
   logic [NUM_SOURCES-1:0] en      [NUM_TARGETS];
   logic [PRIO_W-1:0]      thr     [NUM_TARGETS];
   logic [TW-1:0]          owner   [NUM_SOURCES];
   logic [IW-1:0]          best_id [NUM_TARGETS];
   logic [IW-1:0]          best_n  [NUM_TARGETS];
   logic [NUM_SOURCES-1:0] trig, edge_pend, claimed, src_q, pend;
   logic [NUM_SOURCES-1:0] set_v, clr_v, trig_n, edge_n;

   logic              aw_held, w_held, bvalid_q, rvalid_q;
   logic [AWIDTH-1:0] awaddr_q;
   logic [DWIDTH-1:0] wdata_q, rdata_q, rd_n;
   logic              awready, wready, aw_hs, w_hs, ar_hs, commit, rd_pend, claim_fire;
   logic [IW-1:0]     claim_id;
   dec_t              wdec, rdec;

   assign awready = !aw_held && !bvalid_q;
   assign wready  = !w_held && !bvalid_q;
   assign aw_hs   = axi_if.awvalid && awready;
   assign w_hs    = axi_if.wvalid && wready;
   assign ar_hs   = axi_if.arvalid && !rvalid_q;
   assign commit  = aw_held && w_held;
   assign wdec    = decode(awaddr_q);
   assign rdec    = decode(axi_if.araddr);
   assign rd_pend = (axi_if.araddr[1:0] == 2'b00) && (32'(axi_if.araddr[6:2]) < NW)
                    && (axi_if.araddr[AWIDTH-1:7] == (AWIDTH-7)'(32'h20));

   assign axi_if.awready = awready;
   assign axi_if.wready  = wready;
   assign axi_if.bvalid  = bvalid_q;
   assign axi_if.bresp   = 2'b00;
   assign axi_if.arready = !rvalid_q;
   assign axi_if.rvalid  = rvalid_q;
   assign axi_if.rdata   = rdata_q;
   assign axi_if.rresp   = 2'b00;

   // Gateway: level sources mask themselves while claimed; edge sources keep a one-deep latch
   assign pend = ((trig & edge_pend) | (~trig & source & ~claimed)) & SRC_MASK;

   always_comb begin
      for (int t = 0; t < NUM_TARGETS; t++) begin
         logic [PRIO_W-1:0] bp;
         bp        = thr[t];
         best_n[t] = '0;
         for (int i = 1; i < NUM_SOURCES; i++) begin
            if (pend[i] && !claimed[i] && en[t][i] && (prio[i] > bp)) begin
               bp        = prio[i];
               best_n[t] = IW'(i);
            end
         end
      end
   end

   always_comb begin
      rd_n     = '0;
      claim_id = '0;
      for (int w = 0; w < NW; w++) begin
         for (int j = 0; j < 32; j++) begin
            if ((32 * w + j < NUM_SOURCES) && (rdec.word == 5'(w))) begin
               if (rd_pend)      rd_n[j] = pend[32*w+j];
               if (rdec.is_trig) rd_n[j] = trig[32*w+j];
               for (int t = 0; t < NUM_TARGETS; t++)
                  if (rdec.is_en && (rdec.ctx == 6'(t))) rd_n[j] = en[t][32*w+j];
            end
         end
      end
      for (int i = 0; i < NUM_SOURCES; i++)
         if (rdec.is_prio && (rdec.idx == 10'(i))) rd_n[PRIO_W-1:0] = prio[i];
      for (int t = 0; t < NUM_TARGETS; t++) begin
         if (rdec.ctx == 6'(t)) begin
            if (rdec.is_thr)   rd_n[PRIO_W-1:0] = thr[t];
            if (rdec.is_claim) claim_id = best_id[t];
         end
      end
      if (rdec.is_claim) rd_n[IW-1:0] = claim_id;
   end

   assign claim_fire = ar_hs && rdec.is_claim && (claim_id != '0);

   // Complete checks the claimed/owner state from before this cycle's claim
   always_comb begin
      set_v  = '0;
      clr_v  = '0;
      trig_n = trig;
      for (int i = 1; i < NUM_SOURCES; i++) begin
         if (claim_fire && (claim_id == IW'(i))) set_v[i] = 1'b1;
         if (commit && wdec.is_claim && (wdata_q == DWIDTH'(i)) && claimed[i]
             && (owner[i] == wdec.ctx[TW-1:0])) clr_v[i] = 1'b1;
         if (commit && wdec.is_trig && (wdec.word == 5'(i / 32))) trig_n[i] = wdata_q[i % 32];
      end
      edge_n = ((edge_pend & ~set_v) | (source & ~src_q & trig)) & ~(trig ^ trig_n) & SRC_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         trig      <= '0;
         edge_pend <= '0;
         claimed   <= '0;
         src_q     <= '0;
         target    <= '0;
         for (int i = 0; i < NUM_SOURCES; i++) begin
            prio[i]  <= '0;
            owner[i] <= '0;
         end
         for (int t = 0; t < NUM_TARGETS; t++) begin
            en[t]      <= '0;
            thr[t]     <= '0;
            best_id[t] <= '0;
         end
      end else begin
         if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= axi_if.awaddr;
         end
         if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= axi_if.wdata;
         end
         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
         end else if (bvalid_q && axi_if.bready) begin
            bvalid_q <= 1'b0;
         end
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_n;
         end else if (rvalid_q && axi_if.rready) begin
            rvalid_q <= 1'b0;
         end
         src_q     <= source;
         trig      <= trig_n;
         edge_pend <= edge_n;
         claimed   <= (claimed & ~clr_v) | set_v;
         for (int i = 1; i < NUM_SOURCES; i++) begin
            if (commit && wdec.is_prio && (wdec.idx == 10'(i))) prio[i] <= wdata_q[PRIO_W-1:0];
            if (set_v[i]) owner[i] <= rdec.ctx[TW-1:0];
            for (int t = 0; t < NUM_TARGETS; t++)
               if (commit && wdec.is_en && (wdec.ctx == 6'(t)) && (wdec.word == 5'(i / 32)))
                  en[t][i] <= wdata_q[i % 32];
         end
         for (int t = 0; t < NUM_TARGETS; t++) begin
            if (commit && wdec.is_thr && (wdec.ctx == 6'(t))) thr[t] <= wdata_q[PRIO_W-1:0];
            best_id[t] <= best_n[t];
            target[t]  <= (best_n[t] != '0);
         end
      end
   end
endmodule

// File: tb/tb_plic_gen2.sv
// tb/tb_plic_gen2.sv - self-checking bench for plic_gen2: directed feature scenarios
// plus randomized level-source claim/complete rounds against a behavioural model
module tb_plic_gen2;
   localparam int NS = 32;
   localparam int NT = 2;
   localparam int PW = 3;
   localparam logic [31:0] A_PEND = 32'h1000;
   localparam logic [31:0] A_TRIG = 32'h1080;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NS-1:0] source;
   logic [NT-1:0] target;
   int            n_cmp = 0;
   int            n_bad = 0;

   axi4lite_if #(.AWIDTH(32), .DWIDTH(32)) axi ();

   plic_gen2 #(.AWIDTH(32), .DWIDTH(32), .NUM_SOURCES(NS), .NUM_TARGETS(NT), .PRIO_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .source(source), .target(target), .axi_if(axi)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Behavioural model: what the controller should offer each context
   int            m_prio [NS];
   bit            m_en   [NT][NS];
   int            m_thr  [NT];
   bit            m_claimed [NS];
   int            m_owner [NS];
   bit [NS-1:0]   m_src;

   function automatic int model_best(input int t);
      int top = -1;
      for (int i = 1; i < NS; i++)
         if (m_src[i] && !m_claimed[i] && m_en[t][i] && m_prio[i] > m_thr[t] && m_prio[i] > top)
            top = m_prio[i];
      for (int i = 1; i < NS; i++)
         if (m_src[i] && !m_claimed[i] && m_en[t][i] && m_prio[i] > m_thr[t] && m_prio[i] == top)
            return i;
      return 0;
   endfunction

   function automatic logic [31:0] a_prio(input int i);  return 32'(4 * i); endfunction
   function automatic logic [31:0] a_en(input int t);    return 32'h2000 + 32'(t) * 32'h80; endfunction
   function automatic logic [31:0] a_thr(input int t);   return 32'h200000 + 32'(t) * 32'h1000; endfunction
   function automatic logic [31:0] a_claim(input int t); return a_thr(t) + 32'd4; endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int order,
                            input int bhold, output int held, output logic b_after);
      int   n;
      logic a_ok, w_ok;
      held = 0;
      if (order != 1) begin axi.awaddr = addr; axi.awvalid = 1'b1; end
      if (order != 2) begin axi.wdata = data;  axi.wvalid  = 1'b1; end
      n = 0;
      while (axi.awvalid || axi.wvalid) begin
         a_ok = axi.awvalid && axi.awready;
         w_ok = axi.wvalid && axi.wready;
         tick(1);
         if (a_ok) axi.awvalid = 1'b0;
         if (w_ok) axi.wvalid  = 1'b0;
         if (order == 1 && w_ok) begin axi.awaddr = addr; axi.awvalid = 1'b1; end
         if (order == 2 && a_ok) begin axi.wdata = data;  axi.wvalid  = 1'b1; end
         n++;
         if (n > 20) begin $display("FAIL axi_write_accept addr=%h", addr); $fatal(1); end
      end
      n = 0;
      while (!axi.bvalid) begin
         tick(1);
         n++;
         if (n > 20) begin $display("FAIL axi_write_bvalid addr=%h", addr); $fatal(1); end
      end
      repeat (bhold) begin
         tick(1);
         if (axi.bvalid) held++;
      end
      axi.bready = 1'b1;
      tick(1);
      axi.bready = 1'b0;
      b_after = axi.bvalid;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int rhold,
                           output logic [31:0] data, output int stable);
      int n;
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      n = 0;
      while (!axi.arready) begin
         tick(1);
         n++;
         if (n > 20) begin $display("FAIL axi_read_accept addr=%h", addr); $fatal(1); end
      end
      tick(1);
      axi.arvalid = 1'b0;
      n = 0;
      while (!axi.rvalid) begin
         tick(1);
         n++;
         if (n > 20) begin $display("FAIL axi_read_rvalid addr=%h", addr); $fatal(1); end
      end
      data   = axi.rdata;
      stable = 0;
      repeat (rhold) begin
         tick(1);
         if (axi.rvalid && axi.rdata === data) stable++;
      end
      axi.rready = 1'b1;
      tick(1);
      axi.rready = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      int   h;
      logic b;
      axi_write(addr, data, 0, 0, h, b);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      int s;
      axi_read(addr, 0, data, s);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic [31:0] addrs [6];
      addrs = '{a_prio(2), a_en(0), a_thr(0), A_TRIG, A_PEND, a_claim(0)};
      rst_n = 1'b0;
      source = '0;
      axi.awvalid = 0; axi.wvalid = 0; axi.bready = 0; axi.arvalid = 0; axi.rready = 0;
      axi.awaddr = 0; axi.wdata = 0; axi.araddr = 0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      n_cmp++; if (target !== 2'b00) begin n_bad++; $display("FAIL reset_target got %b want 00", target); end
      n_cmp++; if ({axi.arready, axi.rvalid, axi.awready, axi.wready, axi.bvalid} !== 5'b10110) begin
         n_bad++; $display("FAIL reset_handshake got %b want 10110",
                           {axi.arready, axi.rvalid, axi.awready, axi.wready, axi.bvalid});
      end
      wr(a_prio(2), 1);
      wr(a_en(0), 32'h4);
      source[2] = 1'b1;
      tick(2);
      n_cmp++; if (target !== 2'b01) begin n_bad++; $display("FAIL pre_reset_target got %b want 01", target); end
      axi.araddr = a_prio(2);
      axi.arvalid = 1'b1;
      tick(1);
      axi.arvalid = 1'b0;
      n_cmp++; if (axi.rvalid !== 1'b1) begin n_bad++; $display("FAIL midread_rvalid got %b want 1", axi.rvalid); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({target, axi.rvalid} !== 3'b000) begin
         n_bad++; $display("FAIL async_reset got target=%b rvalid=%b want 0", target, axi.rvalid);
      end
      tick(1);
      rst_n = 1'b1;
      source = '0;
      tick(1);
      n_cmp++; if ({axi.arready, axi.rvalid} !== 2'b10) begin
         n_bad++; $display("FAIL post_reset_ar got arready=%b rvalid=%b want 1/0", axi.arready, axi.rvalid);
      end
      for (int k = 0; k < 6; k++) begin
         rd(addrs[k], d);
         n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_reg addr=%h got %h want 0", addrs[k], d); end
      end
   endtask

   task automatic test_level_priority;
      logic [31:0] d;
      int exp_ids [4] = '{3, 5, 7, 0};
      wr(a_prio(3), 2); wr(a_prio(5), 2); wr(a_prio(7), 1);
      wr(a_en(0), 32'hA8); wr(a_thr(0), 0);
      source[3] = 1; source[5] = 1; source[7] = 1;
      tick(2);
      n_cmp++; if (target[0] !== 1'b1) begin n_bad++; $display("FAIL level_target_rise got %b want 1", target[0]); end
      for (int k = 0; k < 4; k++) begin
         rd(a_claim(0), d);
         n_cmp++; if (d !== 32'(exp_ids[k])) begin n_bad++; $display("FAIL level_claim_%0d got %0d want %0d", k, d, exp_ids[k]); end
      end
      tick(2);
      n_cmp++; if (target[0] !== 1'b0) begin n_bad++; $display("FAIL level_target_fall got %b want 0", target[0]); end
      source = '0;
      wr(a_claim(0), 3); wr(a_claim(0), 5); wr(a_claim(0), 7); wr(a_en(0), 0);
   endtask

   task automatic test_threshold;
      logic [31:0] d;
      wr(a_prio(4), 2); wr(a_en(0), 32'h10); wr(a_thr(0), 2);
      source[4] = 1;
      tick(2);
      n_cmp++; if (target[0] !== 1'b0) begin n_bad++; $display("FAIL thr_equal_target got %b want 0", target[0]); end
      rd(a_claim(0), d);
      n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL thr_equal_claim got %0d want 0", d); end
      wr(a_thr(0), 1);
      tick(2);
      n_cmp++; if (target[0] !== 1'b1) begin n_bad++; $display("FAIL thr_below_target got %b want 1", target[0]); end
      rd(a_thr(0), d);
      n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL thr_readback got %0d want 1", d); end
      rd(a_claim(0), d);
      n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL thr_claim got %0d want 4", d); end
      source = '0;
      wr(a_claim(0), 4); wr(a_en(0), 0); wr(a_thr(0), 0);
   endtask

   task automatic test_edge_latch;
      logic [31:0] d;
      wr(A_TRIG, 32'h201);
      rd(A_TRIG, d);
      n_cmp++; if (d !== 32'h200) begin n_bad++; $display("FAIL trig_readback got %h want 00000200", d); end
      wr(a_prio(9), 1); wr(a_en(1), 32'h200);
      source[9] = 1; tick(1); source[9] = 0;
      tick(2);
      n_cmp++; if (target[1] !== 1'b1) begin n_bad++; $display("FAIL edge_target got %b want 1", target[1]); end
      rd(a_claim(1), d);
      n_cmp++; if (d !== 32'd9) begin n_bad++; $display("FAIL edge_claim got %0d want 9", d); end
      source[9] = 1; tick(1); source[9] = 0;
      tick(2);
      rd(A_PEND, d);
      n_cmp++; if (d !== 32'h200) begin n_bad++; $display("FAIL edge_repend got %h want 00000200", d); end
      n_cmp++; if (target[1] !== 1'b0) begin n_bad++; $display("FAIL edge_claimed_target got %b want 0", target[1]); end
      wr(a_claim(1), 9);
      tick(2);
      n_cmp++; if (target[1] !== 1'b1) begin n_bad++; $display("FAIL edge_after_complete got %b want 1", target[1]); end
      rd(a_claim(1), d);
      n_cmp++; if (d !== 32'd9) begin n_bad++; $display("FAIL edge_reclaim got %0d want 9", d); end
      wr(a_claim(1), 9);
      source[9] = 1; tick(1); source[9] = 0;
      tick(2);
      wr(A_TRIG, 32'h0);
      wr(A_TRIG, 32'h200);
      rd(A_PEND, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mode_change_clear got %h want 0", d); end
      wr(A_TRIG, 32'h0); wr(a_en(1), 0);
   endtask

   task automatic test_ownership;
      logic [31:0] d;
      wr(a_prio(6), 3); wr(a_en(0), 32'h40); wr(a_en(1), 32'h40);
      source[6] = 1;
      tick(2);
      rd(a_claim(0), d);
      n_cmp++; if (d !== 32'd6) begin n_bad++; $display("FAIL own_claim0 got %0d want 6", d); end
      wr(a_claim(1), 6);
      tick(2);
      rd(A_PEND, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL own_wrong_ctx got pend=%h want 0", d); end
      n_cmp++; if (target !== 2'b00) begin n_bad++; $display("FAIL own_wrong_target got %b want 00", target); end
      wr(a_claim(0), 38);
      wr(a_claim(0), 6);
      tick(2);
      rd(A_PEND, d);
      n_cmp++; if (d !== 32'h40) begin n_bad++; $display("FAIL own_repend got %h want 00000040", d); end
      n_cmp++; if (target !== 2'b11) begin n_bad++; $display("FAIL own_target got %b want 11", target); end
      rd(a_claim(1), d);
      n_cmp++; if (d !== 32'd6) begin n_bad++; $display("FAIL own_claim1 got %0d want 6", d); end
      wr(a_claim(0), 6);
      tick(2);
      n_cmp++; if (target !== 2'b00) begin n_bad++; $display("FAIL own_ctx0_ignored got %b want 00", target); end
      wr(a_claim(1), 6);
      tick(2);
      n_cmp++; if (target !== 2'b11) begin n_bad++; $display("FAIL own_ctx1_complete got %b want 11", target); end
      source = '0;
      wr(a_en(0), 0); wr(a_en(1), 0);
   endtask

   task automatic test_axi_ordering;
      logic [31:0] d;
      int   h, s;
      logic b;
      for (int ord = 0; ord < 3; ord++) begin
         axi_write(a_prio(10 + ord), 32'(ord + 2), ord, 5, h, b);
         n_cmp++; if (h !== 5 || b !== 1'b0) begin
            n_bad++; $display("FAIL bvalid_hold_ord%0d got held=%0d after=%b want 5/0", ord, h, b);
         end
         rd(a_prio(10 + ord), d);
         n_cmp++; if (d !== 32'(ord + 2)) begin n_bad++; $display("FAIL write_ord%0d got %0d want %0d", ord, d, ord + 2); end
      end
      wr(a_prio(13), 32'hFFFF_FFFD);
      rd(a_prio(13), d);
      n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL prio_width got %0d want 5", d); end
      axi_read(a_prio(11), 4, d, s);
      n_cmp++; if (d !== 32'd3 || s !== 4) begin n_bad++; $display("FAIL rdata_stable got %0d/%0d want 3/4", d, s); end
      rd(32'h0030_0000, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read got %h want 0", d); end
      for (int i = 10; i < 14; i++) wr(a_prio(i), 0);
   endtask

   task automatic test_random;
      logic [31:0] d, w;
      int exp_id, t;
      for (int it = 0; it < 4; it++) begin
         for (int i = 1; i < NS; i++) begin
            m_prio[i] = $urandom_range(0, 7);
            m_claimed[i] = 0;
            wr(a_prio(i), 32'(m_prio[i]));
         end
         for (int c = 0; c < NT; c++) begin
            w = $urandom;
            for (int i = 0; i < NS; i++) m_en[c][i] = (i != 0) && w[i];
            wr(a_en(c), w);
            rd(a_en(c), d);
            n_cmp++; if (d !== (w & ~32'h1)) begin n_bad++; $display("FAIL rand_en%0d got %h want %h", c, d, w & ~32'h1); end
            m_thr[c] = $urandom_range(0, 3);
            wr(a_thr(c), 32'(m_thr[c]));
         end
         m_src = NS'($urandom) & ~NS'(1);
         source = m_src;
         tick(2);
         for (int c = 0; c < NT; c++) begin
            n_cmp++; if (target[c] !== (model_best(c) != 0)) begin
               n_bad++; $display("FAIL rand_target%0d got %b want %b", c, target[c], model_best(c) != 0);
            end
         end
         for (int k = 0; k < 6; k++) begin
            t = $urandom_range(0, NT - 1);
            exp_id = model_best(t);
            rd(a_claim(t), d);
            n_cmp++; if (d !== 32'(exp_id)) begin n_bad++; $display("FAIL rand_claim ctx%0d got %0d want %0d", t, d, exp_id); end
            if (exp_id != 0) begin m_claimed[exp_id] = 1; m_owner[exp_id] = t; end
         end
         for (int i = 1; i < NS; i++) begin
            if (m_claimed[i]) begin
               wr(a_claim(1 - m_owner[i]), 32'(i));
               tick(2);
               for (int c = 0; c < NT; c++) begin
                  n_cmp++; if (target[c] !== (model_best(c) != 0)) begin
                     n_bad++; $display("FAIL rand_wrong_owner%0d src=%0d got %b want %b", c, i, target[c], model_best(c) != 0);
                  end
               end
               wr(a_claim(m_owner[i]), 32'(i));
               m_claimed[i] = 0;
            end
         end
         tick(2);
         rd(A_PEND, d);
         n_cmp++; if (d !== 32'(m_src)) begin n_bad++; $display("FAIL rand_pend got %h want %h", d, m_src); end
         for (int c = 0; c < NT; c++) begin
            n_cmp++; if (target[c] !== (model_best(c) != 0)) begin
               n_bad++; $display("FAIL rand_final_target%0d got %b want %b", c, target[c], model_best(c) != 0);
            end
         end
         source = '0;
      end
   endtask

   initial begin
      test_reset();
      test_level_priority();
      test_threshold();
      test_edge_latch();
      test_ownership();
      test_axi_ordering();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
